// File: rtl/store_buffer.sv
// Speculative store buffer: holds LSU stores until commit, drains committed stores in
// program order to the data bus, and merges buffered store bytes into load read data.
module store_buffer #(
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int SIZE_WIDTH     = 3,
    parameter int ROB_ID_WIDTH   = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exlsu_stbuf_push,
    input  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
    input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
    input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size,
    input  logic [BUS_DATA_WIDTH-1:0] exlsu_stbuf_write_data,
    output logic                      stbuf_exlsu_full,
    input  logic                      exlsu_stbuf_read_req,
    input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_read_addr,
    input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_read_size,
    output logic                      stbuf_exlsu_bus_ready,
    output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data,
    output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback,
    input  logic                      commit_rob_id_valid,
    input  logic [ROB_ID_WIDTH-1:0]   commit_rob_id,
    input  logic                      commit_flush,
    output logic                      bus_req,
    output logic                      bus_write,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [SIZE_WIDTH-1:0]     bus_size,
    output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
    input  logic                      bus_ack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BYTES = BUS_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int AXW   = ADDR_WIDTH + 1;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state, state_next;

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] commit_cnt;

    logic [DEPTH-1:0] ent_valid, ent_committed;
    logic [DEPTH-1:0] commit_hit, valid_next, committed_next;

    logic [ROB_ID_WIDTH-1:0]   ent_rob  [DEPTH];
    logic [ADDR_WIDTH-1:0]     ent_addr [DEPTH];
    logic [SIZE_WIDTH-1:0]     ent_size [DEPTH];
    logic [BUS_DATA_WIDTH-1:0] ent_data [DEPTH];

    logic [ADDR_WIDTH-1:0]     wr_addr_q;
    logic [SIZE_WIDTH-1:0]     wr_size_q;
    logic [BUS_DATA_WIDTH-1:0] wr_data_q;

    logic full, push_ok, read_grant, drain_start, pop;

    assign full        = (count == CNT_W'(DEPTH));
    assign push_ok     = exlsu_stbuf_push && !full && !commit_flush;
    assign read_grant  = (state == IDLE) && exlsu_stbuf_read_req;
    assign drain_start = (state == IDLE) && !read_grant && ent_valid[head] && ent_committed[head];
    assign pop         = (state == WRITE) && bus_ack;

    // Per-entry flag update: commit first, then flush keeps only committed entries,
    // then the drained head is retired and the pushed slot is claimed.
    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // assignment; a path that leaves a variable unassigned infers a latch.
        commit_hit = '0;
        commit_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            commit_hit[k] = commit_rob_id_valid && ent_valid[k] && (ent_rob[k] == commit_rob_id);
        end
        committed_next = ent_committed | commit_hit;
        for (int k = 0; k < DEPTH; k++) begin
            commit_cnt = commit_cnt + CNT_W'(ent_valid[k] && committed_next[k]);
        end
        valid_next = ent_valid;
        if (commit_flush) begin
            valid_next     = ent_valid & committed_next;
            committed_next = committed_next & valid_next;
        end
        if (pop) begin
            valid_next[head]     = 1'b0;
            committed_next[head] = 1'b0;
        end
        if (push_ok) begin
            valid_next[tail]     = 1'b1;
            committed_next[tail] = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (drain_start) state_next = WRITE;
            WRITE:   if (bus_ack)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            ent_committed <= '0;
            wr_addr_q     <= '0;
            wr_size_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state         <= state_next;
            ent_valid     <= valid_next;
            ent_committed <= committed_next;
            if (drain_start) begin
                wr_addr_q <= ent_addr[head];
                wr_size_q <= ent_size[head];
                wr_data_q <= ent_data[head];
            end
            if (pop) head <= head + 1'b1;
            if (commit_flush) begin
                // Survivors are exactly the committed run starting at head.
                tail  <= head + commit_cnt[PTR_W-1:0];
                count <= commit_cnt - CNT_W'(pop);
            end else begin
                if (push_ok) tail <= tail + 1'b1;
                count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            end
        end
    end

    // NOTE: entry payload has no reset; the valid bits alone say whether a slot
    // holds anything, so clearing the storage arrays would be wasted logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            ent_rob[tail]  <= exlsu_stbuf_rob_id;
            ent_addr[tail] <= exlsu_stbuf_write_addr;
            ent_size[tail] <= exlsu_stbuf_write_size;
            ent_data[tail] <= exlsu_stbuf_write_data;
        end
    end

    logic [BUS_DATA_WIDTH-1:0] fwd_data;
    logic [AXW-1:0]            byte_addr, ent_lo, ent_hi;
    logic [PTR_W-1:0]          scan_idx;
    logic [OFF_W-1:0]          byte_off;

    // Scan oldest to youngest so the youngest covering store owns each lane.
    always_comb begin
        fwd_data  = bus_rdata;
        byte_addr = '0;
        ent_lo    = '0;
        ent_hi    = '0;
        scan_idx  = '0;
        byte_off  = '0;
        for (int lane = 0; lane < BYTES; lane++) begin
            byte_addr = {1'b0, exlsu_stbuf_read_addr} + AXW'(lane);
            for (int k = 0; k < DEPTH; k++) begin
                scan_idx = head + PTR_W'(k);
                ent_lo   = {1'b0, ent_addr[scan_idx]};
                ent_hi   = ent_lo + AXW'(ent_size[scan_idx]);
                if (ent_valid[scan_idx] && (byte_addr >= ent_lo) && (byte_addr < ent_hi)) begin
                    byte_off = OFF_W'(byte_addr - ent_lo);
                    fwd_data[lane*8 +: 8] = ent_data[scan_idx][{byte_off, 3'b000} +: 8];
                end
            end
        end
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        stbuf_exlsu_full              = 1'b0;
        stbuf_exlsu_bus_ready         = 1'b0;
        stbuf_exlsu_bus_data          = '0;
        stbuf_exlsu_bus_data_feedback = '0;
        bus_req                       = 1'b0;
        bus_write                     = 1'b0;
        bus_addr                      = '0;
        bus_size                      = '0;
        bus_wdata                     = '0;
        if (rst) begin
            stbuf_exlsu_full              = full;
            stbuf_exlsu_bus_ready         = read_grant && bus_ack;
            stbuf_exlsu_bus_data          = bus_rdata;
            stbuf_exlsu_bus_data_feedback = fwd_data;
            if (state == WRITE) begin
                bus_req   = 1'b1;
                bus_write = 1'b1;
                bus_addr  = wr_addr_q;
                bus_size  = wr_size_q;
                bus_wdata = wr_data_q;
            end else if (read_grant) begin
                bus_req  = 1'b1;
                bus_addr = exlsu_stbuf_read_addr;
                bus_size = exlsu_stbuf_read_size;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed plus randomized bench for store_buffer, checked every cycle against a
// queue-based reference model of the buffer contents and drain state.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        exlsu_stbuf_push;
    logic [6:0]  exlsu_stbuf_rob_id;
    logic [31:0] exlsu_stbuf_write_addr;
    logic [2:0]  exlsu_stbuf_write_size;
    logic [31:0] exlsu_stbuf_write_data;
    logic        stbuf_exlsu_full;
    logic        exlsu_stbuf_read_req;
    logic [31:0] exlsu_stbuf_read_addr;
    logic [2:0]  exlsu_stbuf_read_size;
    logic        stbuf_exlsu_bus_ready;
    logic [31:0] stbuf_exlsu_bus_data;
    logic [31:0] stbuf_exlsu_bus_data_feedback;
    logic        commit_rob_id_valid;
    logic [6:0]  commit_rob_id;
    logic        commit_flush;
    logic        bus_req;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [2:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk                           (clk),
        .rst                           (rst),
        .exlsu_stbuf_push              (exlsu_stbuf_push),
        .exlsu_stbuf_rob_id            (exlsu_stbuf_rob_id),
        .exlsu_stbuf_write_addr        (exlsu_stbuf_write_addr),
        .exlsu_stbuf_write_size        (exlsu_stbuf_write_size),
        .exlsu_stbuf_write_data        (exlsu_stbuf_write_data),
        .stbuf_exlsu_full              (stbuf_exlsu_full),
        .exlsu_stbuf_read_req          (exlsu_stbuf_read_req),
        .exlsu_stbuf_read_addr         (exlsu_stbuf_read_addr),
        .exlsu_stbuf_read_size         (exlsu_stbuf_read_size),
        .stbuf_exlsu_bus_ready         (stbuf_exlsu_bus_ready),
        .stbuf_exlsu_bus_data          (stbuf_exlsu_bus_data),
        .stbuf_exlsu_bus_data_feedback (stbuf_exlsu_bus_data_feedback),
        .commit_rob_id_valid           (commit_rob_id_valid),
        .commit_rob_id                 (commit_rob_id),
        .commit_flush                  (commit_flush),
        .bus_req                       (bus_req),
        .bus_write                     (bus_write),
        .bus_addr                      (bus_addr),
        .bus_size                      (bus_size),
        .bus_wdata                     (bus_wdata),
        .bus_ack                       (bus_ack),
        .bus_rdata                     (bus_rdata)
    );

    typedef struct {
        int          rob;
        longint      addr;
        int          size;
        logic [31:0] data;
        bit          committed;
    } ent_t;

    ent_t  q[$];
    bit    m_write;
    int    next_rob;
    int    n_cmp;
    int    n_mis;
    string phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s:%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_fb(input logic [31:0] ra, input logic [31:0] rd);
        logic [31:0] fb;
        logic [31:0] sh;
        longint      ba;
        fb = rd;
        for (int lane = 0; lane < 4; lane++) begin
            ba = longint'(ra) + lane;
            foreach (q[k]) begin
                if (ba >= q[k].addr && ba < q[k].addr + q[k].size) begin
                    sh = q[k].data >> (8 * (ba - q[k].addr));
                    fb[lane*8 +: 8] = sh[7:0];
                end
            end
        end
        return fb;
    endfunction

    function automatic int oldest_unc();
        foreach (q[i]) if (!q[i].committed) return q[i].rob;
        return -1;
    endfunction

    task automatic compare_outputs();
        bit grant;
        if (!rst) begin
            check("rst_full", 32'(stbuf_exlsu_full), 32'd0);
            check("rst_req", 32'(bus_req), 32'd0);
            check("rst_write", 32'(bus_write), 32'd0);
            check("rst_ready", 32'(stbuf_exlsu_bus_ready), 32'd0);
            check("rst_data", stbuf_exlsu_bus_data, 32'd0);
            check("rst_fb", stbuf_exlsu_bus_data_feedback, 32'd0);
            check("rst_addr", bus_addr, 32'd0);
            check("rst_wdata", bus_wdata, 32'd0);
            return;
        end
        grant = !m_write && exlsu_stbuf_read_req;
        check("full", 32'(stbuf_exlsu_full), 32'(q.size() == 16));
        check("bus_req", 32'(bus_req), 32'(m_write || grant));
        check("bus_write", 32'(bus_write), 32'(m_write));
        check("ready", 32'(stbuf_exlsu_bus_ready), 32'(grant && bus_ack));
        check("bus_data", stbuf_exlsu_bus_data, bus_rdata);
        check("feedback", stbuf_exlsu_bus_data_feedback, model_fb(exlsu_stbuf_read_addr, bus_rdata));
        if (m_write) begin
            check("wr_addr", bus_addr, 32'(q[0].addr));
            check("wr_size", 32'(bus_size), 32'(q[0].size));
            check("wr_data", bus_wdata, q[0].data);
        end else if (grant) begin
            check("rd_addr", bus_addr, exlsu_stbuf_read_addr);
            check("rd_size", 32'(bus_size), 32'(exlsu_stbuf_read_size));
        end
    endtask

    task automatic model_update();
        bit   pop, grant, start, was_full;
        ent_t kept[$];
        if (!rst) begin
            q.delete();
            m_write = 1'b0;
            return;
        end
        pop      = m_write && bus_ack;
        grant    = !m_write && exlsu_stbuf_read_req;
        start    = !m_write && !grant && q.size() > 0 && q[0].committed;
        was_full = (q.size() == 16);
        if (commit_rob_id_valid)
            foreach (q[i]) if (q[i].rob == int'(commit_rob_id)) q[i].committed = 1'b1;
        if (commit_flush) begin
            foreach (q[i]) if (q[i].committed) kept.push_back(q[i]);
            q = kept;
        end
        if (pop) void'(q.pop_front());
        if (exlsu_stbuf_push && !was_full && !commit_flush)
            q.push_back('{rob: int'(exlsu_stbuf_rob_id), addr: longint'(exlsu_stbuf_write_addr),
                          size: int'(exlsu_stbuf_write_size), data: exlsu_stbuf_write_data,
                          committed: 1'b0});
        if (pop) m_write = 1'b0;
        else if (start) m_write = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_in();
        exlsu_stbuf_push       = 1'b0;
        exlsu_stbuf_rob_id     = '0;
        exlsu_stbuf_write_addr = '0;
        exlsu_stbuf_write_size = '0;
        exlsu_stbuf_write_data = '0;
        exlsu_stbuf_read_req   = 1'b0;
        exlsu_stbuf_read_addr  = '0;
        exlsu_stbuf_read_size  = '0;
        commit_rob_id_valid    = 1'b0;
        commit_rob_id          = '0;
        commit_flush           = 1'b0;
        bus_ack                = 1'b0;
        bus_rdata              = $urandom;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        exlsu_stbuf_push       = 1'b1;
        exlsu_stbuf_rob_id     = 7'(next_rob);
        exlsu_stbuf_write_addr = a;
        exlsu_stbuf_write_size = sz;
        exlsu_stbuf_write_data = d;
        next_rob               = (next_rob + 1) % 128;
    endtask

    task automatic do_commit_oldest();
        int c;
        c = oldest_unc();
        if (c >= 0) begin
            commit_rob_id_valid = 1'b1;
            commit_rob_id       = 7'(c);
        end
    endtask

    task automatic drain_all();
        for (int n = 0; n < 200 && q.size() > 0; n++) begin
            idle_in();
            do_commit_oldest();
            bus_ack = 1'b1;
            cycle();
        end
        idle_in();
        cycle();
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        next_rob = 10;
        m_write  = 1'b0;

        phase = "reset";
        rst = 1'b0;
        idle_in();
        exlsu_stbuf_read_req = 1'b1;
        exlsu_stbuf_push     = 1'b1;
        bus_ack              = 1'b1;
        bus_rdata            = 32'hDEADBEEF;
        cycle();
        cycle();
        rst = 1'b1;
        idle_in();
        cycle();

        phase = "sw_drain";
        idle_in();
        exlsu_stbuf_push       = 1'b1;
        exlsu_stbuf_rob_id     = 7'd3;
        exlsu_stbuf_write_addr = 32'h100;
        exlsu_stbuf_write_size = 3'd4;
        exlsu_stbuf_write_data = 32'hAABBCCDD;
        cycle();
        idle_in();
        commit_rob_id_valid = 1'b1;
        commit_rob_id       = 7'd3;
        cycle();
        idle_in();
        cycle();
        idle_in();
        #2;
        check("lit_write", 32'(bus_write), 32'd1);
        check("lit_addr", bus_addr, 32'h100);
        check("lit_size", 32'(bus_size), 32'd4);
        check("lit_wdata", bus_wdata, 32'hAABBCCDD);
        cycle();
        cycle();
        bus_ack = 1'b1;
        cycle();
        idle_in();
        #2;
        check("lit_req_after", 32'(bus_req), 32'd0);
        cycle();

        phase = "fill";
        for (int i = 0; i < 16; i++) begin
            idle_in();
            do_push(32'h300 + 32'(4 * i), 3'd4, $urandom);
            cycle();
        end
        idle_in();
        #2;
        check("lit_full16", 32'(stbuf_exlsu_full), 32'd1);
        do_push(32'h3F0, 3'd4, 32'h12345678);
        cycle();
        idle_in();
        #2;
        check("lit_full17", 32'(stbuf_exlsu_full), 32'd1);
        do_commit_oldest();
        cycle();
        idle_in();
        cycle();
        idle_in();
        bus_ack = 1'b1;
        cycle();
        idle_in();
        #2;
        check("lit_notfull", 32'(stbuf_exlsu_full), 32'd0);
        do_push(32'h400, 3'd2, 32'h0000BEEF);
        cycle();
        idle_in();
        #2;
        check("lit_wrap_full", 32'(stbuf_exlsu_full), 32'd1);
        drain_all();

        phase = "forward";
        idle_in();
        do_push(32'h201, 3'd1, 32'h11);
        cycle();
        idle_in();
        do_push(32'h201, 3'd1, 32'h22);
        cycle();
        idle_in();
        exlsu_stbuf_read_req  = 1'b1;
        exlsu_stbuf_read_addr = 32'h200;
        exlsu_stbuf_read_size = 3'd4;
        bus_ack               = 1'b1;
        bus_rdata             = 32'h44556677;
        #2;
        check("lit_fb", stbuf_exlsu_bus_data_feedback, 32'h44552277);
        check("lit_raw", stbuf_exlsu_bus_data, 32'h44556677);
        check("lit_ready", 32'(stbuf_exlsu_bus_ready), 32'd1);
        cycle();
        idle_in();
        commit_flush = 1'b1;
        cycle();

        phase = "flush";
        for (int i = 0; i < 4; i++) begin
            idle_in();
            exlsu_stbuf_read_req = 1'b1;
            exlsu_stbuf_read_addr = 32'h500;
            exlsu_stbuf_read_size = 3'd4;
            do_push(32'h500 + 32'(4 * i), 3'd4, $urandom);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            idle_in();
            exlsu_stbuf_read_req = 1'b1;
            exlsu_stbuf_read_addr = 32'h500;
            exlsu_stbuf_read_size = 3'd4;
            if (i < 2) do_commit_oldest();
            else begin
                commit_flush = 1'b1;
                do_push(32'h600, 3'd4, 32'hFEEDF00D);
            end
            cycle();
        end
        for (int i = 0; i < 14; i++) begin
            idle_in();
            exlsu_stbuf_read_req = 1'b1;
            exlsu_stbuf_read_addr = 32'h508;
            exlsu_stbuf_read_size = 3'd4;
            if (i == 13) begin
                #2;
                check("lit_not_full13", 32'(stbuf_exlsu_full), 32'd0);
            end
            do_push(32'h700 + 32'(4 * i), 3'd4, $urandom);
            cycle();
        end
        idle_in();
        exlsu_stbuf_read_req = 1'b1;
        #2;
        check("lit_full_after_flush", 32'(stbuf_exlsu_full), 32'd1);
        commit_flush = 1'b1;
        cycle();
        drain_all();

        phase = "rd_vs_wr";
        idle_in();
        do_push(32'h800, 3'd4, 32'h01020304);
        cycle();
        idle_in();
        do_commit_oldest();
        cycle();
        idle_in();
        cycle();
        idle_in();
        exlsu_stbuf_read_req  = 1'b1;
        exlsu_stbuf_read_addr = 32'h800;
        exlsu_stbuf_read_size = 3'd4;
        #2;
        check("lit_wr_block_write", 32'(bus_write), 32'd1);
        check("lit_wr_block_ready", 32'(stbuf_exlsu_bus_ready), 32'd0);
        cycle();
        bus_ack = 1'b1;
        #2;
        check("lit_ack_ready", 32'(stbuf_exlsu_bus_ready), 32'd0);
        cycle();
        #2;
        check("lit_read_after", 32'(stbuf_exlsu_bus_ready), 32'd1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            idle_in();
            exlsu_stbuf_read_req = 1'b1;
            exlsu_stbuf_read_addr = 32'h900;
            exlsu_stbuf_read_size = 3'd4;
            if (i < 2) do_push(32'h900 + 32'(4 * i), 3'd4, $urandom);
            else do_commit_oldest();
            cycle();
        end
        idle_in();
        exlsu_stbuf_read_req = 1'b1;
        exlsu_stbuf_read_addr = 32'h904;
        exlsu_stbuf_read_size = 3'd4;
        bus_ack = 1'b1;
        #2;
        check("lit_rd_first", 32'(bus_write), 32'd0);
        cycle();
        idle_in();
        cycle();
        idle_in();
        #2;
        check("lit_drain_next", 32'(bus_write), 32'd1);
        cycle();
        drain_all();

        phase = "rst_in_write";
        idle_in();
        do_push(32'hA00, 3'd4, 32'hCAFEBABE);
        cycle();
        idle_in();
        do_commit_oldest();
        cycle();
        idle_in();
        cycle();
        idle_in();
        #2;
        check("lit_in_write", 32'(bus_req), 32'd1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        idle_in();
        #2;
        check("lit_req_post_rst", 32'(bus_req), 32'd0);
        check("lit_full_post_rst", 32'(stbuf_exlsu_full), 32'd0);
        cycle();

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            rst = ($urandom_range(0, 499) != 0);
            if ((q.size() < 16 || $urandom_range(0, 9) == 0) && $urandom_range(0, 1) == 1)
                do_push(32'h100 + $urandom_range(0, 15), 3'(1 << $urandom_range(0, 2)), $urandom);
            if ($urandom_range(0, 9) < 4) do_commit_oldest();
            commit_flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 3) begin
                exlsu_stbuf_read_req  = 1'b1;
                exlsu_stbuf_read_addr = 32'h100 + $urandom_range(0, 15);
                exlsu_stbuf_read_size = 3'(1 << $urandom_range(0, 2));
            end
            bus_ack = $urandom_range(0, 1) == 1;
            cycle();
        end
        rst = 1'b1;
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Receives stores pushed by the LSU execute stage and holds them speculatively until commit.
- Drains committed stores in program order to the data bus.
- Serves LSU load requests through the bus. Read data is merged byte-wise with younger buffered stores (store-to-load forwarding) and returned in the same cycle.
- Sits between the LSU execute stage and the data bus; commit information comes from the commit stage.

Parameters:
- DEPTH, 16, number of store entries; power of two, ≥2.
- ADDR_WIDTH, 32, byte address width.
- BUS_DATA_WIDTH, 32, bus data width (4 byte lanes).
- SIZE_WIDTH, 3, access size field width (1/2/4 bytes).
- ROB_ID_WIDTH, 7, ROB identifier width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- exlsu_stbuf_push  in  1  store push strobe.
- exlsu_stbuf_rob_id  in  ROB_ID_WIDTH  ROB id of pushed store.
- exlsu_stbuf_write_addr  in  ADDR_WIDTH  store byte address.
- exlsu_stbuf_write_size  in  SIZE_WIDTH  store size: 1, 2 or 4.
- exlsu_stbuf_write_data  in  BUS_DATA_WIDTH  store data, LSB-aligned.
- stbuf_exlsu_full  out  1  high when count == DEPTH.
- exlsu_stbuf_read_req  in  1  load read request.
- exlsu_stbuf_read_addr  in  ADDR_WIDTH  load byte address.
- exlsu_stbuf_read_size  in  SIZE_WIDTH  load size.
- stbuf_exlsu_bus_ready  out  1  load data valid this cycle.
- stbuf_exlsu_bus_data  out  BUS_DATA_WIDTH  raw bus read data.
- stbuf_exlsu_bus_data_feedback  out  BUS_DATA_WIDTH  read data after forwarding merge.
- commit_rob_id_valid  in  1  one store ROB id retires this cycle.
- commit_rob_id  in  ROB_ID_WIDTH  retiring ROB id.
- commit_flush  in  1  pipeline flush.
- bus_req  out  1  bus transaction request.
- bus_write  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_WIDTH  transaction address.
- bus_size  out  SIZE_WIDTH  transaction size.
- bus_wdata  out  BUS_DATA_WIDTH  write data, LSB-aligned.
- bus_ack  in  1  transaction completes this cycle; read data valid.
- bus_rdata  in  BUS_DATA_WIDTH  read data; byte 0 = mem[bus_addr].

Behaviour:
- Storage and reset:
  - Circular FIFO of DEPTH entries {valid, committed, rob_id, addr, size, data}, with head, tail and count (width log2(DEPTH)+1).
  - Reset (rst==0 at edge): head = tail = count = 0, all valid/committed cleared, FSM = IDLE.
  - During reset, all outputs are 0.
- Push:
  - If exlsu_stbuf_push && !full && !commit_flush, write the entry at tail with committed=0; tail and count increment. Pointers wrap at DEPTH.
  - A push while full is ignored. The LSU is required not to push while full.
- Commit:
  - On commit_rob_id_valid, the valid entry with matching rob_id gets committed=1.
  - Stores commit in order, so committed entries are always contiguous from head.
- Flush:
  - On commit_flush, all uncommitted entries are invalidated and tail = head + committed-count.
  - A commit in the same cycle as a flush is applied first; that entry survives.
- Drain FSM (IDLE, WRITE):
  - IDLE → WRITE when the head entry is valid && committed && no read request is granted this cycle. Latch head addr/size/data into bus registers.
  - WRITE: bus_req=1, bus_write=1; hold until bus_ack. On ack, clear the head entry, increment head, decrement count, return to IDLE.
  - Push, pop and commit may all occur in the same cycle; count = count + push − pop.
  - Flush never cancels an in-flight write (that entry is committed).
- Load read:
  - Granted combinationally when FSM==IDLE && exlsu_stbuf_read_req.
  - While granted: bus_req=1, bus_write=0, bus_addr/bus_size = read inputs.
  - stbuf_exlsu_bus_ready = granted && bus_ack. Zero added latency.
  - In WRITE state the read is not granted and ready=0; the LSU stalls.
  - Read has priority over starting a drain.
- Forwarding:
  - Each byte lane i (0..3) of feedback starts as bus_rdata byte i.
  - Scan valid entries oldest→youngest. If an entry covers byte address read_addr+i (addr ≤ read_addr+i < addr+size), replace lane i with that entry's byte (read_addr+i−addr). The youngest covering entry wins.
  - Lanes ≥ read_size are unused by the LSU but still follow the same rule.
  - Committed-but-not-drained entries participate.
  - Address compare is full-width; no wrap across the address-space top.
- stbuf_exlsu_bus_data = bus_rdata unmodified.

Test Plan:
- Push sw addr 0x100 data 0xAABBCCDD rob 3; commit rob 3; bus_ack after 2 cycles → bus write addr 0x100 size 4 wdata 0xAABBCCDD; count returns to 0.
- Fill 16 pushes → full=1 on the cycle after the 16th push. A 17th push is ignored. Commit and drain one → full=0. Pointers wrap correctly on the next push.
- Buffered sb 0x201 data 0x11, then sb 0x201 data 0x22 (younger); lw 0x200 with bus_rdata 0x44332211… → feedback byte1=0x22, other bytes from the bus.
- 4 entries, first 2 committed; commit_flush → count=2, tail=head+2; a push in the flush cycle is dropped; the two committed entries still drain.
- Read request during WRITE → ready=0 until the write ack. Read and drain-eligible head in IDLE → read granted first, drain starts the next cycle.
- rst low while in WRITE → next cycle bus_req=0, count=0, full=0.
